// File: rtl/uart_pkg.sv
// Shared UART register map, status flag bit positions, reset divisor and FSM state types.
package uart_pkg;
  localparam logic [15:0] DEFAULT_DIVISOR = 16'd1667;

  localparam logic [3:0] ADDR_STATUS  = 4'd0;
  localparam logic [3:0] ADDR_RX_DATA = 4'd1;
  localparam logic [3:0] ADDR_DIVISOR = 4'd2;
  localparam logic [3:0] ADDR_TX_DATA = 4'd3;

  localparam int FLAG_TX_READY     = 0;
  localparam int FLAG_RX_VALID     = 1;
  localparam int FLAG_RX_OVERRUN   = 2;
  localparam int FLAG_RX_FRAME_ERR = 3;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop sync, mid-bit sampling, byte register with valid/overrun/frame-error flags.
// Byte lands one edge after the stop-bit sample; no backpressure, an unread byte is overwritten.
module uart_rx
  import uart_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx,
  input  logic [15:0] divisor,
  input  logic        clear,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_overrun,
  output logic        rx_frame_err
);
  logic s1, s2, prev;
  rx_state_t state, state_n;
  logic [15:0] timer, timer_n;
  logic [2:0]  bit_cnt, bit_n;
  logic [7:0]  shift, shift_n, data_n;
  logic        valid_n, over_n, ferr_n;
  logic [16:0] half;
  logic        bit_done;

  assign half     = ({1'b0, divisor} + 17'd1) >> 1;
  assign bit_done = timer >= divisor;

  always_comb begin
    state_n = state;
    timer_n = timer;
    bit_n   = bit_cnt;
    shift_n = shift;
    data_n  = rx_data;
    valid_n = clear ? 1'b0 : rx_valid;
    over_n  = clear ? 1'b0 : rx_overrun;
    ferr_n  = clear ? 1'b0 : rx_frame_err;
    case (state)
      RX_IDLE: if (prev && !s2) begin
        state_n = RX_START;
        timer_n = '0;
      end
      RX_START: if (({1'b0, timer} + 17'd1) >= half) begin
        timer_n = '0;
        bit_n   = '0;
        state_n = s2 ? RX_IDLE : RX_DATA;
      end else timer_n = 16'(timer + 16'd1);
      RX_DATA: if (bit_done) begin
        timer_n = '0;
        shift_n = {s2, shift[7:1]};
        bit_n   = 3'(bit_cnt + 3'd1);
        if (bit_cnt == 3'd7) state_n = RX_STOP;
      end else timer_n = 16'(timer + 16'd1);
      RX_STOP: if (bit_done) begin
        timer_n = '0;
        // A completing frame overrides a same-cycle clear.
        if (s2) begin
          data_n  = shift;
          over_n  = over_n | rx_valid;
          valid_n = 1'b1;
          state_n = RX_IDLE;
        end else begin
          ferr_n  = 1'b1;
          state_n = RX_WAIT;
        end
      end else timer_n = 16'(timer + 16'd1);
      RX_WAIT: if (s2) state_n = RX_IDLE;
      default: state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1 <= 1'b0; s2 <= 1'b0; prev <= 1'b0;
      state <= RX_IDLE; timer <= '0; bit_cnt <= '0; shift <= '0;
      rx_data <= '0; rx_valid <= 1'b0; rx_overrun <= 1'b0; rx_frame_err <= 1'b0;
    end else begin
      s1 <= rx; s2 <= s1; prev <= s2;
      state <= state_n; timer <= timer_n; bit_cnt <= bit_n; shift <= shift_n;
      rx_data <= data_n; rx_valid <= valid_n; rx_overrun <= over_n; rx_frame_err <= ferr_n;
    end
  end
endmodule

// File: rtl/uart_device.sv
// UART with register interface: TX FSM here, receiver in uart_rx; reads are combinational.
// A TX write is accepted only while idle (flags[0]); writes while busy are dropped.
module uart_device
  import uart_pkg::*;
#(
  parameter logic [15:0] DEFAULT_DIVISOR = uart_pkg::DEFAULT_DIVISOR
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        Rx,
  input  logic [3:0]  control_address,
  input  logic        control_write,
  input  logic [15:0] data_in,
  output logic [7:0]  flags,
  output logic [15:0] control_read,
  output logic        Tx
);
  logic [15:0] divisor;
  tx_state_t   state, state_n;
  logic [15:0] timer, timer_n;
  logic [2:0]  bit_cnt, bit_n;
  logic [7:0]  shift, shift_n, tx_data, tx_data_n;
  logic        tx_n, bit_done;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_overrun, rx_frame_err;

  assign bit_done = timer >= divisor;

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    bit_n     = bit_cnt;
    shift_n   = shift;
    tx_data_n = tx_data;
    tx_n      = Tx;
    case (state)
      TX_IDLE: if (control_write && control_address == ADDR_TX_DATA) begin
        tx_data_n = data_in[7:0];
        shift_n   = data_in[7:0];
        tx_n      = 1'b0;
        timer_n   = '0;
        state_n   = TX_START;
      end
      TX_START: if (bit_done) begin
        timer_n = '0;
        tx_n    = shift[0];
        shift_n = shift >> 1;
        bit_n   = '0;
        state_n = TX_DATA;
      end else timer_n = 16'(timer + 16'd1);
      TX_DATA: if (bit_done) begin
        timer_n = '0;
        if (bit_cnt == 3'd7) begin
          tx_n    = 1'b1;
          state_n = TX_STOP;
        end else begin
          tx_n    = shift[0];
          shift_n = shift >> 1;
          bit_n   = 3'(bit_cnt + 3'd1);
        end
      end else timer_n = 16'(timer + 16'd1);
      TX_STOP: if (bit_done) begin
        timer_n = '0;
        state_n = TX_IDLE;
      end else timer_n = 16'(timer + 16'd1);
      default: state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      divisor <= DEFAULT_DIVISOR;
      state <= TX_IDLE; timer <= '0; bit_cnt <= '0; shift <= '0; tx_data <= '0; Tx <= 1'b1;
    end else begin
      if (control_write && control_address == ADDR_DIVISOR) divisor <= data_in;
      state <= state_n; timer <= timer_n; bit_cnt <= bit_n; shift <= shift_n;
      tx_data <= tx_data_n; Tx <= tx_n;
    end
  end

  uart_rx u_rx (
    .clock        (clock),
    .reset_n      (reset_n),
    .rx           (Rx),
    .divisor      (divisor),
    .clear        (control_write && control_address == ADDR_RX_DATA),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err)
  );

  always_comb begin
    flags = '0;
    flags[FLAG_TX_READY]     = (state == TX_IDLE);
    flags[FLAG_RX_VALID]     = rx_valid;
    flags[FLAG_RX_OVERRUN]   = rx_overrun;
    flags[FLAG_RX_FRAME_ERR] = rx_frame_err;
  end

  always_comb begin
    case (control_address)
      ADDR_STATUS:  control_read = {8'h00, flags};
      ADDR_RX_DATA: control_read = {8'h00, rx_data};
      ADDR_DIVISOR: control_read = divisor;
      ADDR_TX_DATA: control_read = {8'h00, tx_data};
      default:      control_read = 16'h0000;
    endcase
  end
endmodule

// File: tb/tb_uart_device.sv
// Directed bench for uart_device: register map, TX framing, RX framing/flags and reset behaviour.
module tb_uart_device;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        Rx;
  logic [3:0]  control_address;
  logic        control_write;
  logic [15:0] data_in;
  logic [7:0]  flags;
  logic [15:0] control_read;
  logic        Tx;

  int compared = 0;
  int mism = 0;

  uart_device dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .Rx              (Rx),
    .control_address (control_address),
    .control_write   (control_write),
    .data_in         (data_in),
    .flags           (flags),
    .control_read    (control_read),
    .Tx              (Tx)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one write strobe for exactly one rising edge; returns at the following negedge.
  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    control_address = a;
    data_in = d;
    control_write = 1'b1;
    @(negedge clock);
    control_write = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int bit_clks);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      Rx = f[i];
      repeat (bit_clks) @(negedge clock);
    end
    Rx = 1'b1;
    repeat (3 * bit_clks) @(negedge clock);
  endtask

  task automatic rd(input logic [3:0] a, input string tag, input logic [15:0] exp);
    control_address = a;
    #1;
    chk(tag, control_read, exp);
  endtask

  initial begin
    logic [9:0] seq;
    bit seen;
    reset_n = 1'b0;
    Rx = 1'b1;
    control_address = 4'd0;
    control_write = 1'b0;
    data_in = 16'h0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Reset state
    chk("reset_flags", {8'h00, flags}, 16'h0001);
    chk("reset_tx", {15'h0, Tx}, 16'h0001);
    rd(4'd2, "reset_divisor", 16'd1667);
    rd(4'd1, "reset_rxdata", 16'h0000);
    rd(4'd3, "reset_txdata", 16'h0000);

    // Divisor write is visible right after its edge; unmapped addresses read zero
    wr(4'd2, 16'h0001);
    rd(4'd2, "divisor_write", 16'h0001);
    wr(4'd9, 16'hBEEF);
    rd(4'd9, "unmapped_read", 16'h0000);

    // TX 0xAA with 2 clocks per bit
    wr(4'd3, 16'h00AA);
    seq = {1'b1, 8'hAA, 1'b0};
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("tx_bit%0d", k), {15'h0, Tx}, {15'h0, seq[k/2]});
      chk($sformatf("tx_busy%0d", k), {15'h0, flags[0]}, 16'h0000);
      @(negedge clock);
    end
    chk("tx_done_ready", {15'h0, flags[0]}, 16'h0001);
    chk("tx_done_line", {15'h0, Tx}, 16'h0001);
    rd(4'd3, "txdata_readback", 16'h00AA);

    // Write held at address 3: exactly one idle clock between frames
    control_address = 4'd3;
    data_in = 16'h0055;
    control_write = 1'b1;
    @(negedge clock);
    chk("hold_start_ready", {15'h0, flags[0]}, 16'h0000);
    chk("hold_start_line", {15'h0, Tx}, 16'h0000);
    for (int k = 1; k < 20; k++) begin
      @(negedge clock);
      chk($sformatf("hold_busy%0d", k), {15'h0, flags[0]}, 16'h0000);
    end
    @(negedge clock);
    chk("hold_gap_ready", {15'h0, flags[0]}, 16'h0001);
    chk("hold_gap_line", {15'h0, Tx}, 16'h0001);
    @(negedge clock);
    chk("hold_restart_ready", {15'h0, flags[0]}, 16'h0000);
    chk("hold_restart_line", {15'h0, Tx}, 16'h0000);
    data_in = 16'h0033;
    @(negedge clock);
    chk("busy_write_ignored", control_read, 16'h0055);
    control_write = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clock);
      if (flags[0]) seen = 1'b1;
    end
    chk("hold_second_frame_done", {15'h0, seen}, 16'h0001);

    // RX with divisor 3 (4 clocks per bit)
    wr(4'd2, 16'h0003);
    repeat (4) @(negedge clock);
    send_rx(8'h5A, 1'b1, 4);
    chk("rx1_flags", {8'h00, flags}, 16'h0003);
    rd(4'd1, "rx1_data", 16'h005A);
    send_rx(8'hC3, 1'b1, 4);
    chk("rx2_overrun_flags", {8'h00, flags}, 16'h0007);
    rd(4'd1, "rx2_data", 16'h00C3);
    wr(4'd1, 16'hFFFF);
    chk("rx_clear1", {13'h0, flags[3:1]}, 16'h0000);
    send_rx(8'h11, 1'b1, 4);
    chk("rx3_flags", {8'h00, flags}, 16'h0003);
    send_rx(8'h0F, 1'b0, 4);
    chk("rx_frame_err_flags", {8'h00, flags}, 16'h000B);
    rd(4'd1, "rx_frame_err_data_kept", 16'h0011);
    wr(4'd1, 16'h0000);
    chk("rx_clear2", {13'h0, flags[3:1]}, 16'h0000);

    // Reset mid TX frame, with Rx held low across reset
    wr(4'd3, 16'h00FF);
    repeat (5) @(negedge clock);
    chk("pre_reset_busy", {15'h0, flags[0]}, 16'h0000);
    reset_n = 1'b0;
    Rx = 1'b0;
    control_address = 4'd2;
    @(negedge clock);
    chk("midreset_tx", {15'h0, Tx}, 16'h0001);
    chk("midreset_flags", {8'h00, flags}, 16'h0001);
    rd(4'd2, "midreset_divisor", 16'd1667);
    rd(4'd3, "midreset_txdata", 16'h0000);
    reset_n = 1'b1;
    @(negedge clock);

    // A line held low since reset is never taken as a start bit
    wr(4'd2, 16'h0000);
    repeat (30) @(negedge clock);
    chk("low_line_no_frame", {8'h00, flags}, 16'h0001);
    Rx = 1'b1;
    repeat (10) @(negedge clock);
    chk("low_line_release", {8'h00, flags}, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
